// File: rtl/qdr_arb_pkg.sv
// Shared definitions for the QDR request arbiter: FSM encoding, statistics
// counter width and the tag-width helper used to size the port-tag FIFO.
package qdr_arb_pkg;

  typedef enum logic {
    S_WAIT_PHY = 1'b0,
    S_RUN      = 1'b1
  } arb_state_t;

  localparam int STAT_WIDTH = 32;

  // Bits needed to hold a port number; never less than one bit.
  function automatic int tag_width(input int nports);
    return (nports > 2) ? $clog2(nports) : 1;
  endfunction

endpackage

// File: rtl/qdr_arb_tag_fifo.sv
// Port-tag FIFO: remembers which requester issued each outstanding read so
// returned data can be steered back. The head entry is visible combinationally
// on pop_tag. Push and pop in the same cycle leave the occupancy unchanged.
module qdr_arb_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 1
) (
  input  logic             clk0,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_tag,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_tag,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~full;
  assign pop_tag = mem[rd_ptr[AW-1:0]];

  // Tag storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk0) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_tag;
    end
  end

  // Read and write pointers, with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/qdr_req_arbiter.sv
// Round-robin arbiter sharing one QDR controller user port among NPORTS
// requesters. Reads are tagged with the issuing port so returned data is
// steered back to it one cycle after usr_rd_dvld.
// Build option: define QDR_ARB_STATS_EN to build per-port grant counters;
// without it stat_grants is tied to zero.
module qdr_req_arbiter
  import qdr_arb_pkg::*;
#(
  parameter int NPORTS     = 2,
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 72,
  parameter int BE_WIDTH   = 8,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                         clk0,
  input  logic                         reset_n,
  input  logic                         phy_rdy,
  input  logic [NPORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NPORTS-1:0]            req_wr,
  input  logic [NPORTS-1:0]            req_rd,
  input  logic [NPORTS*DATA_WIDTH-1:0] req_wr_data,
  input  logic [NPORTS*BE_WIDTH-1:0]   req_wr_be,
  output logic [NPORTS-1:0]            req_ack,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [NPORTS-1:0]            rsp_dvld,
  output logic [ADDR_WIDTH-1:0]        usr_addr,
  output logic                         usr_wr_strb,
  output logic [DATA_WIDTH-1:0]        usr_wr_data,
  output logic [BE_WIDTH-1:0]          usr_wr_be,
  output logic                         usr_rd_strb,
  input  logic [DATA_WIDTH-1:0]        usr_rd_data,
  input  logic                         usr_rd_dvld,
  output logic                         tag_err,
  output logic [NPORTS*STAT_WIDTH-1:0] stat_grants
);

  localparam int TAG_W = tag_width(NPORTS);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [NPORTS-1:0] eligible;
  logic              grant_vld;
  logic [TAG_W-1:0]  grant_idx;
  logic [TAG_W-1:0]  cand;
  logic [TAG_W-1:0]  rr_ptr;
  logic              run_ok;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [TAG_W-1:0]  fifo_tag;

  logic [ADDR_WIDTH-1:0] addr_arr [NPORTS];
  logic [DATA_WIDTH-1:0] data_arr [NPORTS];
  logic [BE_WIDTH-1:0]   be_arr   [NPORTS];

  for (genvar p = 0; p < NPORTS; p++) begin : g_unpack
    assign addr_arr[p] = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[p] = req_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
    assign be_arr[p]   = req_wr_be[p*BE_WIDTH +: BE_WIDTH];
  end

  assign run_ok    = (state == S_RUN) && phy_rdy;
  assign fifo_push = grant_vld & req_rd[grant_idx];

  // PHY-ready state register.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT_PHY;
    end else begin
      state <= state_nxt;
    end
  end

  // Follow phy_rdy: grants are only allowed once the controller is calibrated.
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT_PHY: if (phy_rdy)  state_nxt = S_RUN;
      S_RUN:      if (!phy_rdy) state_nxt = S_WAIT_PHY;
    endcase
  end

  // A port competes if it requests, was not just acked, and any read it carries has a free tag.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NPORTS; p++) begin
      eligible[p] = (req_wr[p] | req_rd[p]) & ~req_ack[p] & ~(req_rd[p] & fifo_full);
    end
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (run_ok) begin
      for (int i = 1; i <= NPORTS; i++) begin
        cand = TAG_W'((int'(rr_ptr) + i) % NPORTS);
        if (!grant_vld && eligible[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // Issue registers: strobes and ack pulse for one cycle, payload holds between grants.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= TAG_W'(NPORTS - 1);
      req_ack     <= '0;
      usr_wr_strb <= 1'b0;
      usr_rd_strb <= 1'b0;
      usr_addr    <= '0;
      usr_wr_data <= '0;
      usr_wr_be   <= '0;
    end else begin
      req_ack     <= '0;
      usr_wr_strb <= 1'b0;
      usr_rd_strb <= 1'b0;
      if (grant_vld) begin
        rr_ptr      <= grant_idx;
        req_ack     <= NPORTS'(1) << grant_idx;
        usr_wr_strb <= req_wr[grant_idx];
        usr_rd_strb <= req_rd[grant_idx];
        usr_addr    <= addr_arr[grant_idx];
        usr_wr_data <= data_arr[grant_idx];
        usr_wr_be   <= be_arr[grant_idx];
      end
    end
  end

  qdr_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk0     (clk0),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .push_tag (grant_idx),
    .pop      (usr_rd_dvld),
    .pop_tag  (fifo_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Steer returned data to the port at the head of the tag FIFO; an untagged return is flagged.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      rsp_dvld <= '0;
      rsp_data <= '0;
      tag_err  <= 1'b0;
    end else begin
      rsp_dvld <= '0;
      if (usr_rd_dvld) begin
        if (fifo_empty) begin
          tag_err <= 1'b1;
        end else begin
          rsp_dvld <= NPORTS'(1) << fifo_tag;
          rsp_data <= usr_rd_data;
        end
      end
    end
  end

`ifdef QDR_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_cnt [NPORTS];

  // Count acks per port; counters wrap naturally.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NPORTS; p++) begin
        stat_cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (req_ack[p]) begin
          stat_cnt[p] <= stat_cnt[p] + 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_stat
    assign stat_grants[p*STAT_WIDTH +: STAT_WIDTH] = stat_cnt[p];
  end
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_qdr_req_arbiter.sv
// Self-checking bench for qdr_req_arbiter. A queue-based model predicts every
// output each cycle; directed scenarios add literal expectations that pin it.
module tb_qdr_req_arbiter;

  localparam int NPORTS = 2;
  localparam int AW     = 21;
  localparam int DW     = 72;
  localparam int BW     = 8;
  localparam int DEPTH  = 16;
  localparam int SW     = 32;

  logic                 clk0;
  logic                 reset_n;
  logic                 phy_rdy;
  logic [NPORTS*AW-1:0] req_addr;
  logic [NPORTS-1:0]    req_wr;
  logic [NPORTS-1:0]    req_rd;
  logic [NPORTS*DW-1:0] req_wr_data;
  logic [NPORTS*BW-1:0] req_wr_be;
  logic [NPORTS-1:0]    req_ack;
  logic [DW-1:0]        rsp_data;
  logic [NPORTS-1:0]    rsp_dvld;
  logic [AW-1:0]        usr_addr;
  logic                 usr_wr_strb;
  logic [DW-1:0]        usr_wr_data;
  logic [BW-1:0]        usr_wr_be;
  logic                 usr_rd_strb;
  logic [DW-1:0]        usr_rd_data;
  logic                 usr_rd_dvld;
  logic                 tag_err;
  logic [NPORTS*SW-1:0] stat_grants;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  qdr_req_arbiter #(
    .NPORTS     (NPORTS),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BE_WIDTH   (BW),
    .TAG_DEPTH  (DEPTH)
  ) dut (
    .clk0        (clk0),
    .reset_n     (reset_n),
    .phy_rdy     (phy_rdy),
    .req_addr    (req_addr),
    .req_wr      (req_wr),
    .req_rd      (req_rd),
    .req_wr_data (req_wr_data),
    .req_wr_be   (req_wr_be),
    .req_ack     (req_ack),
    .rsp_data    (rsp_data),
    .rsp_dvld    (rsp_dvld),
    .usr_addr    (usr_addr),
    .usr_wr_strb (usr_wr_strb),
    .usr_wr_data (usr_wr_data),
    .usr_wr_be   (usr_wr_be),
    .usr_rd_strb (usr_rd_strb),
    .usr_rd_data (usr_rd_data),
    .usr_rd_dvld (usr_rd_dvld),
    .tag_err     (tag_err),
    .stat_grants (stat_grants)
  );

  initial begin
    clk0 = 1'b0;
    forever #5 clk0 = ~clk0;
  end

  // Model state
  bit                last_valid;
  int                m_last;
  bit                m_run;
  int                tagq[$];
  logic [NPORTS-1:0] exp_ack;
  logic              exp_wr;
  logic              exp_rd;
  logic [AW-1:0]     exp_addr;
  logic [DW-1:0]     exp_wdata;
  logic [BW-1:0]     exp_be;
  logic [NPORTS-1:0] exp_dvld;
  logic [DW-1:0]     exp_rdata;
  logic              exp_tag_err;
`ifdef QDR_ARB_STATS_EN
  int unsigned       exp_stats[NPORTS];
`endif

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NPORTS-1:0] wr, input logic [NPORTS-1:0] rd,
                               input logic dvld, input logic [DW-1:0] rdata);
    req_wr      = wr;
    req_rd      = rd;
    usr_rd_dvld = dvld;
    usr_rd_data = rdata;
  endtask

  // Behavioural model: arbitration by rotating priority, tags in a queue.
  always @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 1'b0;
      m_last = NPORTS - 1;
      tagq.delete();
      exp_ack = '0; exp_wr = 1'b0; exp_rd = 1'b0;
      exp_addr = '0; exp_wdata = '0; exp_be = '0;
      exp_dvld = '0; exp_rdata = '0; exp_tag_err = 1'b0;
`ifdef QDR_ARB_STATS_EN
      for (int p = 0; p < NPORTS; p++) exp_stats[p] = 0;
`endif
    end else begin
      bit g;
      int w;
      int p;
      int t;
      g = 1'b0;
      w = 0;
      if (m_run && phy_rdy) begin
        for (int k = 1; k <= NPORTS; k++) begin
          p = (m_last + k) % NPORTS;
          if (!g && (req_wr[p] || req_rd[p]) && !exp_ack[p] &&
              !(req_rd[p] && tagq.size() >= DEPTH)) begin
            g = 1'b1;
            w = p;
          end
        end
      end
`ifdef QDR_ARB_STATS_EN
      for (int q = 0; q < NPORTS; q++) if (exp_ack[q]) exp_stats[q]++;
`endif
      exp_dvld = '0;
      if (usr_rd_dvld) begin
        if (tagq.size() == 0) begin
          exp_tag_err = 1'b1;
        end else begin
          t = tagq.pop_front();
          exp_dvld[t] = 1'b1;
          exp_rdata = usr_rd_data;
        end
      end
      exp_ack = '0;
      exp_wr = 1'b0;
      exp_rd = 1'b0;
      if (g) begin
        exp_ack[w] = 1'b1;
        exp_wr     = req_wr[w];
        exp_rd     = req_rd[w];
        exp_addr   = req_addr[w*AW +: AW];
        exp_wdata  = req_wr_data[w*DW +: DW];
        exp_be     = req_wr_be[w*BW +: BW];
        m_last     = w;
        if (req_rd[w]) tagq.push_back(w);
      end
      m_run = phy_rdy;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk0) begin
    if (chk_en) begin
      logic [NPORTS*SW-1:0] es;
      es = '0;
`ifdef QDR_ARB_STATS_EN
      for (int p = 0; p < NPORTS; p++) es[p*SW +: SW] = exp_stats[p];
`endif
      checkOutput("m_req_ack",  256'(req_ack),     256'(exp_ack));
      checkOutput("m_wr_strb",  256'(usr_wr_strb), 256'(exp_wr));
      checkOutput("m_rd_strb",  256'(usr_rd_strb), 256'(exp_rd));
      checkOutput("m_addr",     256'(usr_addr),    256'(exp_addr));
      checkOutput("m_wr_data",  256'(usr_wr_data), 256'(exp_wdata));
      checkOutput("m_wr_be",    256'(usr_wr_be),   256'(exp_be));
      checkOutput("m_rsp_dvld", 256'(rsp_dvld),    256'(exp_dvld));
      checkOutput("m_rsp_data", 256'(rsp_data),    256'(exp_rdata));
      checkOutput("m_tag_err",  256'(tag_err),     256'(exp_tag_err));
      checkOutput("m_stats",    256'(stat_grants), 256'(es));
    end
  end

  initial begin
    int acks0;
    logic [NPORTS*SW-1:0] stat_exp;
    reset_n     = 1'b0;
    phy_rdy     = 1'b0;
    req_addr    = {21'h00020, 21'h00010};
    req_wr_data = {72'h222222222222222222, 72'h111111111111111111};
    req_wr_be   = {8'hF0, 8'h0F};
    applyStimulus(2'b00, 2'b00, 1'b0, '0);
    repeat (3) @(posedge clk0);
    #1;
    chk_en = 1'b1;

    // Scenario 1: all ports requesting while the PHY is not ready
    reset_n = 1'b1;
    applyStimulus(2'b11, 2'b00, 1'b0, '0);
    repeat (8) @(posedge clk0);
    @(negedge clk0);
    checkOutput("s1_no_ack", 256'(req_ack), 256'(2'b00));
    checkOutput("s1_no_strb", 256'(usr_wr_strb), 256'(1'b0));
    phy_rdy = 1'b1;
    @(posedge clk0); @(negedge clk0);
    checkOutput("s1_ack_wait", 256'(req_ack), 256'(2'b00));
    @(posedge clk0); @(negedge clk0);
    checkOutput("s1_first_ack", 256'(req_ack), 256'(2'b01));
    checkOutput("s1_first_addr", 256'(usr_addr), 256'(21'h10));
    checkOutput("s1_first_strb", 256'(usr_wr_strb), 256'(1'b1));

    // Scenario 2: both writers held, grants alternate
    @(posedge clk0); @(negedge clk0);
    checkOutput("s2_addr_a", 256'(usr_addr), 256'(21'h20));
    checkOutput("s2_ack_a", 256'(req_ack), 256'(2'b10));
    @(posedge clk0); @(negedge clk0);
    checkOutput("s2_addr_b", 256'(usr_addr), 256'(21'h10));
    checkOutput("s2_ack_b", 256'(req_ack), 256'(2'b01));
    @(posedge clk0); @(negedge clk0);
    checkOutput("s2_addr_c", 256'(usr_addr), 256'(21'h20));
    checkOutput("s2_strb_c", 256'(usr_wr_strb), 256'(1'b1));
    applyStimulus(2'b00, 2'b00, 1'b0, '0);
    repeat (3) @(posedge clk0);
    @(negedge clk0);

    // Scenario 3: port 1 issues three reads, three returns in order
    applyStimulus(2'b00, 2'b10, 1'b0, '0);
    repeat (5) @(posedge clk0);
    @(negedge clk0);
    checkOutput("s3_third_rd", 256'(usr_rd_strb), 256'(1'b1));
    applyStimulus(2'b00, 2'b00, 1'b0, '0);
    repeat (2) @(posedge clk0);
    @(negedge clk0);
    applyStimulus(2'b00, 2'b00, 1'b1, 72'hA0A1A2A3A4A5A6A7A8);
    @(posedge clk0); @(negedge clk0);
    checkOutput("s3_dvld_a", 256'(rsp_dvld), 256'(2'b10));
    checkOutput("s3_data_a", 256'(rsp_data), 256'(72'hA0A1A2A3A4A5A6A7A8));
    applyStimulus(2'b00, 2'b00, 1'b1, 72'hB0B1B2B3B4B5B6B7B8);
    @(posedge clk0); @(negedge clk0);
    checkOutput("s3_dvld_b", 256'(rsp_dvld), 256'(2'b10));
    checkOutput("s3_data_b", 256'(rsp_data), 256'(72'hB0B1B2B3B4B5B6B7B8));
    applyStimulus(2'b00, 2'b00, 1'b1, 72'hC0C1C2C3C4C5C6C7C8);
    @(posedge clk0); @(negedge clk0);
    checkOutput("s3_dvld_c", 256'(rsp_dvld), 256'(2'b10));
    checkOutput("s3_data_c", 256'(rsp_data), 256'(72'hC0C1C2C3C4C5C6C7C8));
    applyStimulus(2'b00, 2'b00, 1'b0, '0);
    @(posedge clk0); @(negedge clk0);
    checkOutput("s3_dvld_off", 256'(rsp_dvld), 256'(2'b00));

    // Scenario 4: fill the tag FIFO with port 1 reads while port 0 writes
    applyStimulus(2'b01, 2'b10, 1'b0, '0);
    repeat (40) @(posedge clk0);
    @(negedge clk0);
    acks0 = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk0); @(negedge clk0);
      checkOutput("s4_rd_blocked", 256'(usr_rd_strb), 256'(1'b0));
      if (req_ack[0]) acks0++;
    end
    checkOutput("s4_wr_acks", 256'(acks0), 256'(2));
    applyStimulus(2'b01, 2'b10, 1'b1, 72'hD0D1D2D3D4D5D6D7D8);
    @(posedge clk0); @(negedge clk0);
    checkOutput("s4_pop_dvld", 256'(rsp_dvld), 256'(2'b10));
    applyStimulus(2'b01, 2'b10, 1'b0, '0);
    @(posedge clk0); @(negedge clk0);
    checkOutput("s4_rd_resume", 256'(usr_rd_strb), 256'(1'b1));
    checkOutput("s4_rd_ack", 256'(req_ack), 256'(2'b10));
    applyStimulus(2'b00, 2'b00, 1'b0, '0);
    @(posedge clk0); @(negedge clk0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(2'b00, 2'b00, 1'b1, DW'(i + 1));
      @(posedge clk0); @(negedge clk0);
    end
    applyStimulus(2'b00, 2'b00, 1'b0, '0);
    @(posedge clk0); @(negedge clk0);

    // Scenario 5: return with an empty FIFO, then asynchronous reset mid-burst
    applyStimulus(2'b00, 2'b00, 1'b1, 72'hEE);
    @(posedge clk0); @(negedge clk0);
    checkOutput("s5_tag_err", 256'(tag_err), 256'(1'b1));
    checkOutput("s5_no_dvld", 256'(rsp_dvld), 256'(2'b00));
    applyStimulus(2'b11, 2'b00, 1'b0, '0);
    repeat (4) @(posedge clk0);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("s5_rst_ack", 256'(req_ack), 256'(2'b00));
    checkOutput("s5_rst_strb", 256'(usr_wr_strb), 256'(1'b0));
    checkOutput("s5_rst_err", 256'(tag_err), 256'(1'b0));
    checkOutput("s5_rst_addr", 256'(usr_addr), 256'(21'h0));
    applyStimulus(2'b00, 2'b00, 1'b0, '0);
    repeat (2) @(posedge clk0);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk0);
    @(negedge clk0);

    // Scenario 6: five grants to port 0, three to port 1
    applyStimulus(2'b01, 2'b00, 1'b0, '0);
    repeat (9) @(posedge clk0);
    @(negedge clk0);
    applyStimulus(2'b00, 2'b00, 1'b0, '0);
    repeat (2) @(posedge clk0);
    @(negedge clk0);
    applyStimulus(2'b10, 2'b00, 1'b0, '0);
    repeat (5) @(posedge clk0);
    @(negedge clk0);
    applyStimulus(2'b00, 2'b00, 1'b0, '0);
    repeat (3) @(posedge clk0);
    @(negedge clk0);
`ifdef QDR_ARB_STATS_EN
    stat_exp = {32'd3, 32'd5};
`else
    stat_exp = '0;
`endif
    checkOutput("s6_stats", 256'(stat_grants), 256'(stat_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
